// File: rtl/vector_processor.sv
// Vector core: 512x32 data memory, four 16-lane x 32-bit registers.
// One load/store/add/multiply instruction completes on every clock edge.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous active-low reset
//   op_code           00 load, 01 store, 10 add, 11 multiply
//   reg_addr_to_write load destination register (0..3 = A1..A4)
//   reg_addr_to_read  store source register and data_out select
//   mem_addr          base word address for load/store (wraps at 512)
//   data_out          combinational view of regs[reg_addr_to_read]
module vector_processor (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   op_code,
   input  logic [1:0]   reg_addr_to_write,
   input  logic [1:0]   reg_addr_to_read,
   input  logic [8:0]   mem_addr,
   output logic [511:0] data_out
);

   logic [511:0][31:0]     mem;
   logic [3:0][15:0][31:0] regs;

   logic [15:0][31:0] sum_lo;
   logic [15:0][31:0] sum_hi;
   logic [15:0][31:0] prod_lo;
   logic [15:0][31:0] prod_hi;

   // A 64-bit add leaves the carry in bit 32, so the upper word of the
   // sum is exactly the zero-extended carry written to A4.
   always_comb begin
      sum_lo  = '0;
      sum_hi  = '0;
      prod_lo = '0;
      prod_hi = '0;
      for (int k = 0; k < 16; k++) begin
         {sum_hi[k], sum_lo[k]} =
            {32'd0, regs[0][k]} + {32'd0, regs[1][k]};
         {prod_hi[k], prod_lo[k]} =
            {32'd0, regs[0][k]} * {32'd0, regs[1][k]};
      end
   end

   // The 9-bit lane address sum wraps naturally past word 511.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 512; i++) begin
            mem[i] <= 32'(i);
         end
         regs <= '0;
      end else begin
         unique case (op_code)
            2'b00: begin
               for (int k = 0; k < 16; k++) begin
                  regs[reg_addr_to_write][k] <= mem[mem_addr + 9'(k)];
               end
            end
            2'b01: begin
               for (int k = 0; k < 16; k++) begin
                  mem[mem_addr + 9'(k)] <= regs[reg_addr_to_read][k];
               end
            end
            2'b10: begin
               regs[2] <= sum_lo;
               regs[3] <= sum_hi;
            end
            2'b11: begin
               regs[2] <= prod_lo;
               regs[3] <= prod_hi;
            end
            default: ;
         endcase
      end
   end

   assign data_out = regs[reg_addr_to_read];

endmodule

// File: tb/tb_vector_processor.sv
// Bench for vector_processor: directed program with an instruction-level
// model checked every cycle plus literal checks on key results.
module tb_vector_processor;

   logic         clk;
   logic         rst;
   logic [1:0]   op_code;
   logic [1:0]   reg_addr_to_write;
   logic [1:0]   reg_addr_to_read;
   logic [8:0]   mem_addr;
   logic [511:0] data_out;

   int tests;
   int fails;
   int cyc;

   int unsigned mm[512];
   int unsigned mr[4][16];

   vector_processor dut (
      .clk               (clk),
      .rst               (rst),
      .op_code           (op_code),
      .reg_addr_to_write (reg_addr_to_write),
      .reg_addr_to_read  (reg_addr_to_read),
      .mem_addr          (mem_addr),
      .data_out          (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction-level model: executes whatever is on the inputs at each edge.
   always @(posedge clk) begin
      longint unsigned s;
      int unsigned a;
      cyc = cyc + 1;
      if (!rst) begin
         for (int i = 0; i < 512; i++) mm[i] = i;
         for (int r = 0; r < 4; r++)
            for (int k = 0; k < 16; k++) mr[r][k] = 0;
      end else begin
         case (op_code)
            2'b00:
               for (int k = 0; k < 16; k++) begin
                  a = (int'(mem_addr) + k) % 512;
                  mr[reg_addr_to_write][k] = mm[a];
               end
            2'b01:
               for (int k = 0; k < 16; k++) begin
                  a = (int'(mem_addr) + k) % 512;
                  mm[a] = mr[reg_addr_to_read][k];
               end
            2'b10:
               for (int k = 0; k < 16; k++) begin
                  s = longint'(mr[0][k]) + longint'(mr[1][k]);
                  mr[2][k] = s[31:0];
                  mr[3][k] = 32'(s >> 32);
               end
            default:
               for (int k = 0; k < 16; k++) begin
                  s = longint'(mr[0][k]) * longint'(mr[1][k]);
                  mr[2][k] = s[31:0];
                  mr[3][k] = s[63:32];
               end
         endcase
      end
   end

   // Compare process: data_out against the model after every edge.
   always @(posedge clk) begin
      logic [511:0] exp;
      #1;
      for (int k = 0; k < 16; k++)
         exp[32*k +: 32] = mr[reg_addr_to_read][k];
      tests = tests + 1;
      if (data_out !== exp) begin
         fails = fails + 1;
         $display("FAIL model cyc%0d rd%0d: got %h want %h",
                  cyc, reg_addr_to_read, data_out, exp);
      end
   end

   function automatic logic [511:0] lanes(input logic [31:0] a,
                                          input logic [31:0] m);
      logic [511:0] v;
      for (int k = 0; k < 16; k++) v[32*k +: 32] = a + m * 32'(k);
      return v;
   endfunction

   task automatic step(input logic [1:0] op, input logic [1:0] w,
                       input logic [1:0] r, input logic [8:0] a);
      @(negedge clk);
      rst               = 1'b1;
      op_code           = op;
      reg_addr_to_write = w;
      reg_addr_to_read  = r;
      mem_addr          = a;
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset(input logic [1:0] op, input logic [1:0] r,
                           input logic [8:0] a);
      @(negedge clk);
      rst              = 1'b0;
      op_code          = op;
      reg_addr_to_read = r;
      mem_addr         = a;
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [1:0] r,
                      input logic [511:0] exp);
      reg_addr_to_read = r;
      #1;
      tests = tests + 1;
      if (data_out !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %h want %h", name, data_out, exp);
      end
   endtask

   task automatic chk_lane(input string name, input logic [1:0] r,
                           input int k, input logic [31:0] exp);
      reg_addr_to_read = r;
      #1;
      tests = tests + 1;
      if (data_out[32*k +: 32] !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %h want %h",
                  name, data_out[32*k +: 32], exp);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc   = 0;
      rst               = 1'b0;
      op_code           = 2'b00;
      reg_addr_to_write = 2'd0;
      reg_addr_to_read  = 2'd0;
      mem_addr          = 9'd0;

      do_reset(2'b00, 2'd0, 9'd0);
      do_reset(2'b00, 2'd0, 9'd0);
      for (int r = 0; r < 4; r++) chk("reset_reg", 2'(r), '0);

      // Basic load / add / store / multiply
      step(2'b00, 2'd0, 2'd0, 9'd0);
      chk("load_a1_ramp", 2'd0, lanes(0, 1));
      step(2'b00, 2'd1, 2'd1, 9'd16);
      chk("load_a2_16", 2'd1, lanes(16, 1));
      step(2'b10, 2'd0, 2'd2, 9'd0);
      chk("add_a3", 2'd2, lanes(16, 2));
      chk("add_a4", 2'd3, '0);
      step(2'b01, 2'd0, 2'd2, 9'd32);
      step(2'b00, 2'd1, 2'd1, 9'd32);
      chk("store_readback", 2'd1, lanes(16, 2));
      step(2'b11, 2'd0, 2'd2, 9'd0);
      chk_lane("mul_lane15", 2'd2, 15, 32'd690);
      chk_lane("mul_lane3", 2'd2, 3, 32'd66);
      chk("mul_a4", 2'd3, '0);

      // Build 0xFFFFFFFF = 65535 * 65537 in lane 0
      step(2'b00, 2'd0, 2'd0, 9'd255);
      step(2'b00, 2'd1, 2'd0, 9'd257);
      step(2'b11, 2'd0, 2'd2, 9'd0);
      step(2'b01, 2'd0, 2'd2, 9'd420);
      step(2'b00, 2'd0, 2'd0, 9'd256);
      step(2'b00, 2'd1, 2'd0, 9'd256);
      step(2'b11, 2'd0, 2'd2, 9'd0);
      step(2'b01, 2'd0, 2'd2, 9'd300);
      step(2'b00, 2'd0, 2'd0, 9'd300);
      step(2'b00, 2'd1, 2'd0, 9'd1);
      step(2'b10, 2'd0, 2'd2, 9'd0);
      chk_lane("plus_one", 2'd2, 0, 32'd65537);
      step(2'b01, 2'd0, 2'd2, 9'd400);
      step(2'b00, 2'd0, 2'd0, 9'd420);
      step(2'b00, 2'd1, 2'd0, 9'd400);
      step(2'b11, 2'd0, 2'd2, 9'd0);
      chk_lane("all_ones_lo", 2'd2, 0, 32'hFFFF_FFFF);
      chk_lane("all_ones_hi", 2'd3, 0, 32'h0);
      // Ascending stores replicate lane 0 into words 0..15
      for (int b = 0; b < 16; b++) step(2'b01, 2'd0, 2'd2, 9'(b));
      step(2'b00, 2'd0, 2'd0, 9'd0);
      step(2'b00, 2'd1, 2'd0, 9'd0);
      chk("ovf_a1", 2'd0, lanes(32'hFFFF_FFFF, 0));
      step(2'b10, 2'd0, 2'd2, 9'd0);
      chk("ovf_add_a3", 2'd2, lanes(32'hFFFF_FFFE, 0));
      chk("ovf_add_a4", 2'd3, lanes(1, 0));
      step(2'b11, 2'd0, 2'd2, 9'd0);
      chk("ovf_mul_a3", 2'd2, lanes(1, 0));
      chk("ovf_mul_a4", 2'd3, lanes(32'hFFFF_FFFE, 0));

      // Address wrap past word 511
      do_reset(2'b00, 2'd0, 9'd0);
      step(2'b00, 2'd0, 2'd0, 9'd504);
      chk_lane("wrap_l0", 2'd0, 0, 32'd504);
      chk_lane("wrap_l7", 2'd0, 7, 32'd511);
      chk_lane("wrap_l8", 2'd0, 8, 32'd0);
      chk_lane("wrap_l15", 2'd0, 15, 32'd7);
      step(2'b00, 2'd1, 2'd1, 9'd504);
      step(2'b10, 2'd0, 2'd2, 9'd0);
      step(2'b01, 2'd0, 2'd2, 9'd504);
      step(2'b00, 2'd3, 2'd3, 9'd504);
      chk_lane("wrap_st_l0", 2'd3, 0, 32'd1008);
      chk_lane("wrap_st_l9", 2'd3, 9, 32'd2);
      chk_lane("wrap_st_l15", 2'd3, 15, 32'd14);
      // Holding an opcode re-executes it with the same result
      step(2'b00, 2'd3, 2'd3, 9'd504);
      step(2'b00, 2'd3, 2'd3, 9'd504);
      chk_lane("hold_load", 2'd3, 0, 32'd1008);

      // Reset wins over a held store
      do_reset(2'b01, 2'd3, 9'd0);
      for (int r = 0; r < 4; r++) chk("rst_store_reg", 2'(r), '0);
      step(2'b00, 2'd0, 2'd0, 9'd0);
      chk("rst_mem_0", 2'd0, lanes(0, 1));
      step(2'b00, 2'd1, 2'd1, 9'd504);
      chk_lane("rst_mem_504", 2'd1, 0, 32'd504);
      chk_lane("rst_mem_wrap", 2'd1, 9, 32'd1);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vector_processor.md
# vector_processor

Single-clock vector processor core with a private 512-word × 32-bit data memory and four 512-bit vector registers (A1..A4, 16 lanes × 32 bits each). Each clock edge executes one instruction selected by `op_code`: vector load, vector store, lane-wise add, or lane-wise multiply. The block sits under an external sequencer/testbench that drives the opcode and addresses every cycle. A debug read port exposes one register.

## Interface
Parameters: none (widths fixed: 32-bit lanes, 16 lanes, 512-word memory).
- `clk` input 1 — rising-edge clock.
- `rst` input 1 — synchronous, active-low reset (0 = reset, sampled on `clk` rising edge).
- `op_code` input 2 — 00 load, 01 store, 10 add, 11 multiply.
- `reg_addr_to_write` input 2 — destination register for load (0=A1, 1=A2, 2=A3, 3=A4).
- `reg_addr_to_read` input 2 — source register for store and for `data_out`.
- `mem_addr` input 9 — base word address for load/store.
- `data_out` output 512 — combinational view of register `reg_addr_to_read`; 0 after reset.

## Operation
- Lane k (0..15) of a register occupies bits [32k+31:32k].
- Internal arrays: `mem[0:511]` (32-bit words), `regs[0:3]` (512-bit).
- Reset (`rst`=0 at edge): all four registers cleared to 0; `mem[i]` initialised to i (zero-extended 9-bit index) for i = 0..511. Reset overrides any opcode.
- Load (00): `regs[reg_addr_to_write]` lane k ← `mem[(mem_addr+k) mod 512]`.
- Store (01): `mem[(mem_addr+k) mod 512]` ← lane k of `regs[reg_addr_to_read]`; registers unchanged.
- Add (10): per lane, 33-bit sum s = A1[k] + A2[k] (unsigned); A3[k] ← s[31:0]; A4[k] ← {31'b0, s[32]} (carry).
- Multiply (11): per lane, 64-bit unsigned product p = A1[k] × A2[k]; A3[k] ← p[31:0]; A4[k] ← p[63:32].
- Add/multiply always read A1, A2 and write A3, A4; `reg_addr_to_*` and `mem_addr` are ignored.
- Address wrap: lanes crossing word 511 wrap to word 0.
- All sources are read as pre-edge values (e.g., store of a register being written elsewhere in the same instruction is impossible; repeated ops are idempotent except multiply/add chains where A1/A2 change only via load).

## Timing
- Every instruction completes in exactly one cycle: result visible in `regs`/`mem` and on `data_out` after the rising edge that samples the opcode.
- Holding an opcode for N cycles re-executes it N times (load/store/add/multiply are idempotent with stable inputs).
- No handshake, no stall, no busy flag; a new opcode may be presented every cycle.
- Inputs must be stable at the rising edge; no mid-cycle effects.
- Reset mid-sequence: next edge with `rst`=0 restores registers to 0 and memory to index pattern regardless of prior state.
- `data_out` updates combinationally when `reg_addr_to_read` changes.

## Test plan
- Reset then load base 0 → A1 (reg 0): A1 lane k = k; `data_out` with read=0 shows lanes 0..15.
- Load base 16 → A2, then add: A3 lane k = 16+2k, A4 all 0; store A3 at base 32 → `mem[32+k]` = 16+2k.
- Load base 32 → A2, multiply (A1 lane k = k): A3 lane k = k·(16+2k) (lane 15 = 690), A4 = 0.
- Overflow: store a register holding 0xFFFFFFFF lanes (built via multiply chain or forced via hierarchical write), load into A1 and A2, add → A3 = 0xFFFFFFFE, A4 = 1; multiply → A3 = 0x00000001, A4 = 0xFFFFFFFE.
- Wrap: load base 504 → A1 lanes = 504..511, 0..7; store at 504 then readback identical.
- Reset with `op_code`=01 held: memory returns to `mem[i]`=i, all registers 0, no store performed.
